// File: rtl/instruction_fetch_unit.sv
//------------------------------------------------------------------------------
// instruction_fetch_unit : holds the architectural PC and fetches the word at it
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instruction_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] programCounterInput,
   input  logic        pcAdvance,
   output logic [31:0] pcOfInstruction,
   output logic [31:0] instruction,
   output logic        instructionValid,
   output logic [31:0] memAddress,
   output logic        memRequest,
   input  logic        memGrant,
   input  logic        memReadValid,
   input  logic [31:0] memReadData,
   output logic        fetchMisaligned,
   output logic        fetchTimeout
);

   localparam int          c_CW     = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam bit          c_TO_EN  = (TIMEOUT_CYCLES != 0);
   localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT_CYCLES - 1);
   localparam logic [c_CW-1:0] c_MAX  = c_CW'(TIMEOUT_CYCLES);

   localparam logic [1:0] S_REQUEST = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_VALID   = 2'd2;
   localparam logic [1:0] S_ERROR   = 2'd3;

   logic [1:0]      r_state;
   logic [1:0]      w_state_nxt;
   logic [31:0]     r_pc;
   logic [31:0]     r_instruction;
   logic            r_misaligned;
   logic            r_timeout;
   logic [c_CW-1:0] r_count;
   logic            w_capture;
   logic            w_misalign_hit;
   logic            w_timeout_hit;
   logic            w_aligned;

   assign w_aligned = (r_pc[1:0] == 2'b00);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_REQUEST;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_capture      = 1'b0;
      w_misalign_hit = 1'b0;
      w_timeout_hit  = 1'b0;
      case (r_state)
         S_REQUEST: begin
            if (!w_aligned) begin
               w_state_nxt    = S_ERROR;
               w_misalign_hit = 1'b1;
            end else if (memGrant && memReadValid) begin
               w_state_nxt = S_VALID;
               w_capture   = 1'b1;
            end else if (memGrant) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            // A response arriving on the last allowed cycle beats the timeout
            if (memReadValid) begin
               w_state_nxt = S_VALID;
               w_capture   = 1'b1;
            end else if (c_TO_EN && (r_count == c_LAST)) begin
               w_state_nxt   = S_ERROR;
               w_timeout_hit = 1'b1;
            end
         end
         S_VALID: begin
            if (pcAdvance) begin
               w_state_nxt = S_REQUEST;
            end
         end
         default: begin
            w_state_nxt = S_ERROR;
         end
      endcase
   end

   always_comb begin
      memRequest       = (r_state == S_REQUEST) && w_aligned;
      instructionValid = (r_state == S_VALID);
      memAddress       = r_pc;
      pcOfInstruction  = r_pc;
      instruction      = r_instruction;
      fetchMisaligned  = r_misaligned;
      fetchTimeout     = r_timeout;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pc          <= RESET_VECTOR;
         r_instruction <= 32'h0000_0000;
         r_misaligned  <= 1'b0;
         r_timeout     <= 1'b0;
         r_count       <= '0;
      end else begin
         if (w_capture) begin
            r_instruction <= memReadData;
         end
         if ((r_state == S_VALID) && pcAdvance) begin
            r_pc <= programCounterInput;
         end
         if (w_misalign_hit) begin
            r_misaligned <= 1'b1;
         end
         if (w_timeout_hit) begin
            r_timeout <= 1'b1;
         end
         // Counter saturates so a disabled timeout can never wrap into a false hit
         if ((r_state == S_REQUEST) && memGrant) begin
            r_count <= '0;
         end else if ((r_state == S_WAIT) && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
//------------------------------------------------------------------------------
// tb_instruction_fetch_unit : directed checks of the instruction fetch unit
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instruction_fetch_unit;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   int          vectors = 0;
   int          miscompares = 0;

   // Instance A: default timeout
   logic [31:0] pci = '0;
   logic        adv = 1'b0;
   logic [31:0] pc_of, instr, addr;
   logic        ivalid, req, mis, tmo;
   logic        grant = 1'b0, rv = 1'b0;
   logic [31:0] rdata = '0;

   // Instance B: short timeout
   logic [31:0] b_pci = '0;
   logic        b_adv = 1'b0;
   logic [31:0] b_pc_of, b_instr, b_addr;
   logic        b_ivalid, b_req, b_mis, b_tmo;
   logic        b_grant = 1'b0, b_rv = 1'b0;
   logic [31:0] b_rdata = '0;

   always #5 clock = ~clock;

   instruction_fetch_unit u_dut (
      .clock(clock), .reset_n(reset_n),
      .programCounterInput(pci), .pcAdvance(adv),
      .pcOfInstruction(pc_of), .instruction(instr), .instructionValid(ivalid),
      .memAddress(addr), .memRequest(req), .memGrant(grant),
      .memReadValid(rv), .memReadData(rdata),
      .fetchMisaligned(mis), .fetchTimeout(tmo)
   );

   instruction_fetch_unit #(.RESET_VECTOR(32'h0), .TIMEOUT_CYCLES(4)) u_dut_to (
      .clock(clock), .reset_n(reset_n),
      .programCounterInput(b_pci), .pcAdvance(b_adv),
      .pcOfInstruction(b_pc_of), .instruction(b_instr), .instructionValid(b_ivalid),
      .memAddress(b_addr), .memRequest(b_req), .memGrant(b_grant),
      .memReadValid(b_rv), .memReadData(b_rdata),
      .fetchMisaligned(b_mis), .fetchTimeout(b_tmo)
   );

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      vectors++; if (ivalid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", ivalid); end
      vectors++; if (req !== 1'b1) begin miscompares++; $display("FAIL reset_req: got %b expected 1", req); end
      vectors++; if (addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 00000000", addr); end
      vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
      vectors++; if ({mis, tmo} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b expected 00", {mis, tmo}); end
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_zero_latency();
      vectors++; if (addr !== 32'h0) begin miscompares++; $display("FAIL zl_addr: got %h expected 00000000", addr); end
      grant = 1'b1; rv = 1'b1; rdata = 32'h0000_0013;
      @(negedge clock);
      grant = 1'b0; rv = 1'b0;
      vectors++; if (ivalid !== 1'b1) begin miscompares++; $display("FAIL zl_valid: got %b expected 1", ivalid); end
      vectors++; if (instr !== 32'h0000_0013) begin miscompares++; $display("FAIL zl_instr: got %h expected 00000013", instr); end
      vectors++; if (pc_of !== 32'h0) begin miscompares++; $display("FAIL zl_pc: got %h expected 00000000", pc_of); end
      vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL zl_req_in_valid: got %b expected 0", req); end
      // Read data arriving while VALID must not disturb the held instruction
      rv = 1'b1; rdata = 32'hBAD0_BAD0;
      @(negedge clock);
      rv = 1'b0;
      vectors++; if (instr !== 32'h0000_0013) begin miscompares++; $display("FAIL valid_rv_ignored: got %h expected 00000013", instr); end
   endtask

   task automatic test_advance();
      adv = 1'b1; pci = 32'h0000_0104;
      @(negedge clock);
      adv = 1'b0;
      vectors++; if (ivalid !== 1'b0) begin miscompares++; $display("FAIL adv_valid: got %b expected 0", ivalid); end
      vectors++; if (req !== 1'b1) begin miscompares++; $display("FAIL adv_req: got %b expected 1", req); end
      vectors++; if (addr !== 32'h0000_0104) begin miscompares++; $display("FAIL adv_addr: got %h expected 00000104", addr); end
      // pcAdvance outside VALID and read data without grant are both ignored
      adv = 1'b1; pci = 32'hDEAD_0000; rv = 1'b1; rdata = 32'h1111_1111;
      @(negedge clock);
      adv = 1'b0; rv = 1'b0;
      vectors++; if (addr !== 32'h0000_0104) begin miscompares++; $display("FAIL adv_ignored_addr: got %h expected 00000104", addr); end
      vectors++; if ({req, ivalid} !== 2'b10) begin miscompares++; $display("FAIL rv_no_grant: got %b expected 10", {req, ivalid}); end
   endtask

   task automatic test_delayed();
      for (int i = 0; i < 4; i++) begin
         vectors++; if ({req, addr} !== {1'b1, 32'h0000_0104}) begin miscompares++; $display("FAIL dly_req_hold%0d: got %b/%h expected 1/00000104", i, req, addr); end
         if (i == 3) grant = 1'b1;
         @(negedge clock);
      end
      grant = 1'b0;
      for (int i = 0; i < 5; i++) begin
         vectors++; if ({req, ivalid} !== 2'b00) begin miscompares++; $display("FAIL dly_wait%0d: got %b expected 00", i, {req, ivalid}); end
         if (i == 4) begin rv = 1'b1; rdata = 32'h00A0_0093; end
         @(negedge clock);
      end
      rv = 1'b0;
      vectors++; if (ivalid !== 1'b1) begin miscompares++; $display("FAIL dly_valid: got %b expected 1", ivalid); end
      vectors++; if (instr !== 32'h00A0_0093) begin miscompares++; $display("FAIL dly_instr: got %h expected 00a00093", instr); end
      vectors++; if (pc_of !== 32'h0000_0104) begin miscompares++; $display("FAIL dly_pc: got %h expected 00000104", pc_of); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_pc [2];
      logic [31:0] exp_in [2];
      exp_pc[0] = 32'h0000_0108; exp_in[0] = 32'h0010_0113;
      exp_pc[1] = 32'h0000_010C; exp_in[1] = 32'h0020_0193;
      for (int i = 0; i < 2; i++) begin
         adv = 1'b1; pci = exp_pc[i];
         @(negedge clock);
         adv = 1'b0; grant = 1'b1; rv = 1'b1; rdata = exp_in[i];
         @(negedge clock);
         grant = 1'b0; rv = 1'b0;
         vectors++; if ({ivalid, pc_of, instr} !== {1'b1, exp_pc[i], exp_in[i]}) begin miscompares++; $display("FAIL b2b_%0d: got %b/%h/%h expected 1/%h/%h", i, ivalid, pc_of, instr, exp_pc[i], exp_in[i]); end
      end
   endtask

   task automatic test_misaligned();
      adv = 1'b1; pci = 32'h0000_0102;
      @(negedge clock);
      adv = 1'b0;
      vectors++; if ({req, ivalid, addr} !== {2'b00, 32'h0000_0102}) begin miscompares++; $display("FAIL mis_first: got %b%b/%h expected 00/00000102", req, ivalid, addr); end
      grant = 1'b1; rv = 1'b1; adv = 1'b1; pci = 32'h0000_0200;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         vectors++; if ({mis, req, ivalid, addr} !== {3'b100, 32'h0000_0102}) begin miscompares++; $display("FAIL mis_sticky%0d: got %b%b%b/%h expected 100/00000102", i, mis, req, ivalid, addr); end
      end
      grant = 1'b0; rv = 1'b0; adv = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      grant = 1'b1; rv = 1'b1; rdata = 32'h0000_0013;
      @(negedge clock);
      grant = 1'b0; rv = 1'b0; adv = 1'b1; pci = 32'h0000_0200;
      @(negedge clock);
      adv = 1'b0; grant = 1'b1;
      @(negedge clock);
      grant = 1'b0;
      vectors++; if ({req, ivalid, addr} !== {2'b00, 32'h0000_0200}) begin miscompares++; $display("FAIL rst_in_wait: got %b%b/%h expected 00/00000200", req, ivalid, addr); end
      #1 reset_n = 1'b0;
      #1;
      vectors++; if ({req, ivalid, addr, instr} !== {2'b10, 32'h0, 32'h0}) begin miscompares++; $display("FAIL rst_async: got %b%b/%h/%h expected 10/00000000/00000000", req, ivalid, addr, instr); end
      @(negedge clock);
      reset_n = 1'b1;
      grant = 1'b1; rv = 1'b1; rdata = 32'h0000_0033;
      @(negedge clock);
      grant = 1'b0; rv = 1'b0;
      vectors++; if ({ivalid, pc_of, instr} !== {1'b1, 32'h0, 32'h0000_0033}) begin miscompares++; $display("FAIL rst_restart: got %b/%h/%h expected 1/00000000/00000033", ivalid, pc_of, instr); end
   endtask

   task automatic test_timeout();
      // Response on the last allowed WAIT cycle is captured
      do_reset();
      b_grant = 1'b1;
      @(negedge clock);
      b_grant = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin b_rv = 1'b1; b_rdata = 32'h0000_0055; end
         @(negedge clock);
      end
      b_rv = 1'b0;
      vectors++; if ({b_ivalid, b_tmo, b_instr} !== {2'b10, 32'h0000_0055}) begin miscompares++; $display("FAIL to_edge_win: got %b%b/%h expected 10/00000055", b_ivalid, b_tmo, b_instr); end
      // No response: timeout after exactly four WAIT cycles
      b_adv = 1'b1; b_pci = 32'h0000_0010;
      @(negedge clock);
      b_adv = 1'b0; b_grant = 1'b1;
      @(negedge clock);
      b_grant = 1'b0;
      for (int i = 0; i < 4; i++) begin
         vectors++; if (b_tmo !== 1'b0) begin miscompares++; $display("FAIL to_early%0d: got %b expected 0", i, b_tmo); end
         @(negedge clock);
      end
      vectors++; if (b_tmo !== 1'b1) begin miscompares++; $display("FAIL to_fire: got %b expected 1", b_tmo); end
      b_rv = 1'b1; b_rdata = 32'h7777_7777; b_adv = 1'b1; b_pci = 32'h0000_0020;
      @(negedge clock);
      @(negedge clock);
      b_rv = 1'b0; b_adv = 1'b0;
      vectors++; if ({b_tmo, b_ivalid, b_req, b_addr, b_instr} !== {3'b100, 32'h0000_0010, 32'h0000_0055}) begin miscompares++; $display("FAIL to_sticky: got %b%b%b/%h/%h expected 100/00000010/00000055", b_tmo, b_ivalid, b_req, b_addr, b_instr); end
      vectors++; if (b_mis !== 1'b0) begin miscompares++; $display("FAIL to_no_mis: got %b expected 0", b_mis); end
   endtask

   initial begin
      test_reset();
      test_zero_latency();
      test_advance();
      test_delayed();
      test_back_to_back();
      test_misaligned();
      test_reset_mid_wait();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
